// File: rtl/riscv_pkg.sv
// Purpose: shared RV32I constants, field bit ranges, register count and sequencer FSM encoding.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;
  localparam int INST_W   = 32;
  localparam int IMM_W    = 12;
  localparam int OPC_W    = 7;

  // Major opcodes, inst[6:0]
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  // Field bit ranges within the instruction word
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int IMM_LSB = 20;
  localparam int IMM_MSB = 31;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] idx);
    reg_onehot = NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/issue_scoreboard_ctrl_fields.sv
// Purpose: split an RV32I word into opcode/rd/rs1/rs2/imm fields.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of inst.
// Ports: inst (in, 32) -> opcode (7), rd/rs1/rs2 (5 each), imm (12, raw inst[31:20]).
module issue_scoreboard_ctrl_fields
  import riscv_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output logic [OPC_W-1:0]  opcode,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  rs1,
  output logic [REG_W-1:0]  rs2,
  output logic [IMM_W-1:0]  imm
);

  assign opcode = inst[OPC_MSB:OPC_LSB];
  assign rd     = inst[RD_MSB:RD_LSB];
  assign rs1    = inst[RS1_MSB:RS1_LSB];
  assign rs2    = inst[RS2_MSB:RS2_LSB];
  assign imm    = inst[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/issue_scoreboard_ctrl.sv
// Purpose: single-issue sequencer; holds one instruction until the register scoreboard shows no RAW/WAW hazard.
// Latency: accept in cycle N -> out_valid in cycle N+2 at best; one instruction per 3 cycles max.
// Backpressure: in_ready only in EMPTY; out_* held stable while out_valid & !out_ready.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_inst from fetch;
//   out_valid/out_ready/out_inst/out_rd/out_rs1/out_rs2/out_imm to execute;
//   wb_valid/wb_rd writeback clears; flush discards the held instruction;
//   pending = scoreboard (bit 0 always 0); stall_cnt only when ISSUE_STALL_CNT_EN is defined.
module issue_scoreboard_ctrl
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_W-1:0]   in_inst,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INST_W-1:0]   out_inst,
  output logic [REG_W-1:0]    out_rd,
  output logic [REG_W-1:0]    out_rs1,
  output logic [REG_W-1:0]    out_rs2,
  output logic [IMM_W-1:0]    out_imm,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] pending
`ifdef ISSUE_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  state_t              state_q, state_d;
  logic [INST_W-1:0]   inst_q;
  logic [OPC_W-1:0]    opcode;
  logic                use_rs1, use_rs2, use_rd;
  logic [NUM_REGS-1:0] wb_mask, eff, pending_d;
  logic                hazard, capture, issue_fire;

  issue_scoreboard_ctrl_fields u_fields (
    .inst   (inst_q),
    .opcode (opcode),
    .rd     (out_rd),
    .rs1    (out_rs1),
    .rs2    (out_rs2),
    .imm    (out_imm)
  );

  assign out_inst = inst_q;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OPC_OP:                begin use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
      OPC_OP_IMM, OPC_LOAD:  begin use_rs1 = 1'b1; use_rd  = 1'b1; end
      OPC_STORE, OPC_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      default:               use_rd = 1'b1;
    endcase
  end

  // A writeback landing this cycle already counts as resolved, so the held
  // instruction can move to ISSUE on the same edge the bit is cleared.
  assign wb_mask = wb_valid ? reg_onehot(wb_rd) : '0;
  assign eff     = pending & ~wb_mask & ~NUM_REGS'(1);
  assign hazard  = (use_rs1 & eff[out_rs1]) | (use_rs2 & eff[out_rs2]) | (use_rd & eff[out_rd]);

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == ST_EMPTY);
    out_valid = (state_q == ST_ISSUE);
    case (state_q)
      ST_EMPTY: if (in_valid)  state_d = ST_HOLD;
      ST_HOLD:  if (!hazard)   state_d = ST_ISSUE;
      ST_ISSUE: if (out_ready) state_d = ST_EMPTY;
      default:                 state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  // Flush overrides the handshake, so a flushed instruction never claims its rd.
  assign capture    = in_valid & in_ready & ~flush;
  assign issue_fire = out_valid & out_ready & ~flush;

  // Clear first, then set, so a set wins a same-index collision.
  always_comb begin
    pending_d = pending & ~wb_mask;
    if (issue_fire && use_rd && (out_rd != '0)) pending_d = pending_d | reg_onehot(out_rd);
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      inst_q  <= '0;
      pending <= '0;
    end else begin
      state_q <= state_d;
      pending <= pending_d;
      if (capture) inst_q <= in_inst;
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state_q == ST_HOLD) && hazard && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/issue_scoreboard_ctrl.md
# issue_scoreboard_ctrl

Single-issue instruction sequencer between fetch and execute. It accepts one 32-bit RV32I instruction at a time and splits out the rd/rs1/rs2/imm fields. It holds the instruction until a per-register scoreboard shows no RAW/WAW hazard, then hands it to execute over a valid/ready handshake. Writeback reports clear the scoreboard.

## Interface
- Parameters: none. Register count is fixed at 32 and taken from the shared package.
- Clock/reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch offers in_inst
- in_ready  out  1  block can capture an instruction
- in_inst  in  32  raw instruction word
- out_valid  out  1  decoded instruction available to execute
- out_ready  in  1  execute accepts
- out_inst  out  32  held instruction word
- out_rd / out_rs1 / out_rs2  out  5 each  inst[11:7] / inst[19:15] / inst[24:20]
- out_imm  out  12  inst[31:20]
- wb_valid  in  1  a write to register wb_rd completes this cycle
- wb_rd  in  5  destination register of the completing write
- flush  in  1  synchronous discard of the held instruction
- pending  out  32  scoreboard bits; bit 0 is always 0
- stall_cnt  out  16  saturating hazard-stall counter (only with the macro in Configuration)

## Operation
- FSM states:
  - EMPTY: reset state; in_ready=1.
  - HOLD: instruction captured; hazard check runs.
  - ISSUE: out_valid=1.
- EMPTY→HOLD when in_valid&in_ready. The fields are registered.
- HOLD→ISSUE in the first cycle where hazard=0. Otherwise the block stays in HOLD.
- ISSUE→EMPTY when out_valid&out_ready.
- flush forces the next state to EMPTY from any state and wins over every transition. A flushed instruction never sets a scoreboard bit. Scoreboard bits are kept on flush.
- Register usage comes from opcode inst[6:0]:
  - R-type 0110011: rs1, rs2, rd.
  - I-type 0010011 and load 0000011: rs1, rd.
  - Store 0100011 and branch 1100011: rs1, rs2; no rd.
  - Any other opcode: rd only.
- hazard = (use_rs1 & eff[rs1]) | (use_rs2 & eff[rs2]) | (use_rd & eff[rd]).
  - eff = pending & ~(wb_valid ? onehot(wb_rd) : 0). A same-cycle writeback therefore unblocks.
  - Index 0 never hazards.
- On the issue handshake, pending[out_rd] is set when use_rd=1 and out_rd≠0.
- On wb_valid, pending[wb_rd] is cleared.
- If a set and a clear hit the same index in the same cycle, the set wins.
- wb_valid for a register that is not pending has no effect. It is not an error.

## Timing
- Reset values:
  - state=EMPTY; in_ready=1; out_valid=0.
  - out_inst, out_rd, out_rs1, out_rs2, out_imm = 0.
  - pending=0; stall_cnt=0.
- Minimum latency: accepted in cycle N → out_valid in cycle N+2.
- Throughput: at most one instruction every 3 cycles. in_ready is high only in EMPTY.
- All out_* fields are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation drops the held instruction and clears every scoreboard bit immediately.

## Configuration
- Macro: ISSUE_STALL_CNT_EN.
- Defined: stall_cnt increments each cycle the FSM is in HOLD with hazard=1. It saturates at 16'hFFFF and clears only on reset.
- Undefined: the stall_cnt port and its counter are absent.

## Structure
- Shared package (riscv_pkg) holds:
  - opcode constants for OP, OP_IMM, LOAD, STORE, BRANCH;
  - the field bit ranges;
  - the register count (32);
  - the FSM state encoding (2 bits: EMPTY=0, HOLD=1, ISSUE=2).
- Sub-module: the existing field-extraction block is instantiated once on the held word. It supplies rd, rs1, rs2 and imm.
- Scoreboard and hazard logic stay in this module.

## Test plan
- Independent instruction: in_inst=ADDI x5,x1,3 with pending=0, out_ready=1. Required: out_valid in cycle N+2, out_rd=5, out_rs1=1, out_imm=3. pending[5]=1 after the handshake.
- RAW stall: issue ADDI x5, then offer ADD x6,x5,x2. Required: the block stays in HOLD with no out_valid. wb_valid with wb_rd=5 → ISSUE on the next cycle.
- Same-cycle writeback bypass: pending[7]=1, and wb_valid with wb_rd=7 arrives in the first HOLD cycle of SW x7,0(x1). Required: ISSUE on the next cycle.
- x0 and store handling:
  - ADDI x0,x0,1 issues and pending stays 0.
  - SW with rd-field bits =5 while pending[5]=1 issues without stalling.
- Flush and backpressure:
  - Flush in ISSUE with out_ready=0 → EMPTY on the next cycle; pending is unchanged.
  - out_ready held low for 4 cycles → out_inst is unchanged throughout.
- With ISSUE_STALL_CNT_EN defined: a 10-cycle RAW stall gives stall_cnt=10. Asserting rst_n low mid-stall returns stall_cnt=0, pending=0, in_ready=1 asynchronously.
